fsm_seq_gen: RTL and testbench

Parametrised step-sequencer FSM, successor to the fixed six-state enable-branch controller.
- Walks a chain of NSTEPS steps. Each step has a programmable output word and a programmable dwell time.
- The entry step is chosen by `enable`: step 0 when high, step ALT_START when low.
- Adds manual/auto launch, hold, abort, and a done pulse.
- Sits between control logic and any datapath that needs a timed output pattern.

---
 rtl/fsm_seq_gen.sv | 108 ++++++++++
 tb/tb_fsm_seq_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_gen.sv
// Step-sequencer FSM: walks NSTEPS programmable steps, each with its own output word and dwell time.
// Optional completed-run counter enabled by defining FSM_SEQ_RUNCNT_EN; otherwise run_cnt is tied to 0.
module fsm_seq_gen #(
   parameter int OUT_W     = 4,
   parameter int NSTEPS    = 5,
   parameter int DWELL_W   = 4,
   parameter int ALT_START = 2,
   parameter int CNT_W     = 8
) (
   input  logic                                          clk,
   input  logic                                          rstb,
   input  logic                                          enable,
   input  logic                                          auto_run,
   input  logic                                          start,
   input  logic                                          hold,
   input  logic                                          abort,
   input  logic [NSTEPS*OUT_W-1:0]                       step_out_tbl,
   input  logic [NSTEPS*DWELL_W-1:0]                     step_dwell_tbl,
   output logic [OUT_W-1:0]                              out,
   output logic [((NSTEPS > 2) ? $clog2(NSTEPS) : 1)-1:0] step,
   output logic                                          busy,
   output logic                                          done,
   output logic [CNT_W-1:0]                              run_cnt
);

   localparam int SW = (NSTEPS > 2) ? $clog2(NSTEPS) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_n;
   logic [OUT_W-1:0]   out_n;
   logic [SW-1:0]      step_n, ld_idx;
   logic               busy_n, done_n, ld_en;
   logic [DWELL_W-1:0] dwell, dwell_n;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state <= IDLE;
         out   <= '0;
         step  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dwell <= '0;
      end else begin
         state <= state_n;
         out   <= out_n;
         step  <= step_n;
         busy  <= busy_n;
         done  <= done_n;
         dwell <= dwell_n;
      end
   end

   // Every step entry (launch or advance) funnels through ld_en so table fields are sampled in one place.
   always_comb begin
      state_n = state;
      out_n   = out;
      step_n  = step;
      busy_n  = busy;
      done_n  = 1'b0;
      dwell_n = dwell;
      ld_en   = 1'b0;
      ld_idx  = step + SW'(1);
      unique case (state)
         IDLE: begin
            out_n   = '0;
            step_n  = '0;
            busy_n  = 1'b0;
            dwell_n = '0;
            if (!abort && (auto_run || start)) begin
               ld_en  = 1'b1;
               ld_idx = enable ? '0 : SW'(ALT_START);
            end
         end
         RUN: begin
            if (abort || (!hold && dwell == '0 && step == SW'(NSTEPS-1))) begin
               state_n = IDLE;
               out_n   = '0;
               step_n  = '0;
               busy_n  = 1'b0;
               dwell_n = '0;
               done_n  = !abort;
            end else if (!hold) begin
               if (dwell != '0) dwell_n = dwell - DWELL_W'(1);
               else             ld_en   = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (ld_en) begin
         state_n = RUN;
         busy_n  = 1'b1;
         step_n  = ld_idx;
         out_n   = step_out_tbl[32'(ld_idx)*OUT_W +: OUT_W];
         dwell_n = step_dwell_tbl[32'(ld_idx)*DWELL_W +: DWELL_W];
      end
   end

`ifdef FSM_SEQ_RUNCNT_EN
   always_ff @(posedge clk) begin
      if (!rstb)                             run_cnt <= '0;
      else if (done_n && run_cnt != '1)      run_cnt <= run_cnt + CNT_W'(1);
   end
`else
   assign run_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Self-checking bench for fsm_seq_gen: directed scenarios plus randomized traffic against a queue-based model.
module tb_fsm_seq_gen;
   localparam int OUT_W = 4, NSTEPS = 5, DWELL_W = 4, ALT_START = 2, CNT_W = 2, SW = 3;

   logic clk = 1'b0;
   logic rstb = 1'b0, enable = 1'b0, auto_run = 1'b0, start = 1'b0, hold = 1'b0, abort = 1'b0;
   logic [NSTEPS*OUT_W-1:0]   step_out_tbl = '0;
   logic [NSTEPS*DWELL_W-1:0] step_dwell_tbl = '0;
   logic [OUT_W-1:0] out;
   logic [SW-1:0]    step;
   logic             busy, done;
   logic [CNT_W-1:0] run_cnt;

   int n_checks = 0, n_fail = 0;

   // Model: a launch expands the whole run into a queue of (out, step) cycles; the front is what is shown.
   typedef struct packed {logic [OUT_W-1:0] o; logic [SW-1:0] s;} ent_t;
   ent_t q[$];
   bit   m_run, m_done;
   int   m_cnt;

   fsm_seq_gen #(.OUT_W(OUT_W), .NSTEPS(NSTEPS), .DWELL_W(DWELL_W), .ALT_START(ALT_START), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstb(rstb), .enable(enable), .auto_run(auto_run), .start(start), .hold(hold),
      .abort(abort), .step_out_tbl(step_out_tbl), .step_dwell_tbl(step_dwell_tbl),
      .out(out), .step(step), .busy(busy), .done(done), .run_cnt(run_cnt));

   always #5 clk = ~clk;

   task automatic build_run();
      int e;
      e = enable ? 0 : ALT_START;
      for (int k = e; k < NSTEPS; k++)
         for (int r = 0; r <= int'(step_dwell_tbl[k*DWELL_W +: DWELL_W]); r++)
            q.push_back('{o: step_out_tbl[k*OUT_W +: OUT_W], s: SW'(k)});
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rstb) begin
         q.delete(); m_run = 0; m_done = 0; m_cnt = 0;
      end else if (m_run) begin
         m_done = 0;
         if (abort) begin
            q.delete(); m_run = 0;
         end else if (!hold) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               m_run = 0; m_done = 1;
               if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
         end
      end else begin
         m_done = 0;
         if (!abort && (auto_run || start)) begin
            build_run(); m_run = 1;
         end
      end
      #1;
   endtask

   function automatic logic [OUT_W+SW+2+CNT_W-1:0] expv();
      logic [OUT_W-1:0] eo;
      logic [SW-1:0]    es;
      logic [CNT_W-1:0] ec;
      eo = m_run ? q[0].o : '0;
      es = m_run ? q[0].s : '0;
`ifdef FSM_SEQ_RUNCNT_EN
      ec = CNT_W'(m_cnt);
`else
      ec = '0;
`endif
      return {eo, es, m_run, m_done, ec};
   endfunction

   task automatic set_common();
      step_out_tbl   = {4'd7, 4'd5, 4'd4, 4'd3, 4'd1};
      step_dwell_tbl = '0;
   endtask

   task automatic do_reset();
      rstb = 0; start = 0; hold = 0; abort = 0; auto_run = 0;
      tick(); tick();
      rstb = 1;
   endtask

   task automatic test_reset();
      set_common();
      rstb = 0; auto_run = 1; enable = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin #2 rstb = 1; #2 rstb = 0; end
         tick();
         n_checks++;
         if ({out, step, busy, done, run_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got out=%0d step=%0d busy=%b done=%b cnt=%0d want all 0",
                     i, out, step, busy, done, run_cnt);
         end
      end
   endtask

   task automatic test_auto_run(input logic en);
      logic [OUT_W-1:0] pat_e [6];
      logic [OUT_W-1:0] pat_a [4];
      int per;
      pat_e = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd0};
      pat_a = '{4'd4, 4'd5, 4'd7, 4'd0};
      per = en ? 6 : 4;
      set_common(); enable = en; do_reset(); auto_run = 1;
      for (int i = 0; i < 3*per; i++) begin
         tick();
         n_checks++;
         if ({out, step, busy, done, run_cnt} !== expv()) begin
            n_fail++;
            $display("FAIL auto_en%0b cyc=%0d got %h want %h", en, i, {out, step, busy, done, run_cnt}, expv());
         end
         n_checks++;
         if (out !== (en ? pat_e[i%6] : pat_a[i%4]) || done !== (i%per == per-1)) begin
            n_fail++;
            $display("FAIL auto_pattern_en%0b cyc=%0d got out=%0d done=%b want out=%0d done=%b", en, i, out, done,
                     en ? pat_e[i%6] : pat_a[i%4], i%per == per-1);
         end
      end
      auto_run = 0;
   endtask

   task automatic test_dwell_hold();
      int n3 = 0, seen3 = 0;
      set_common(); step_dwell_tbl[1*DWELL_W +: DWELL_W] = 4'd3;
      do_reset(); enable = 1; start = 1;
      for (int i = 0; i < 16; i++) begin
         tick();
         start = 0;
         if (busy && out == 4'd3) seen3++;
         n_checks++;
         if ({out, step, busy, done, run_cnt} !== expv()) begin
            n_fail++;
            $display("FAIL dwell_hold cyc=%0d got %h want %h", i, {out, step, busy, done, run_cnt}, expv());
         end
         if (m_run && q[0].s == 1) n3++;
         hold = (n3 == 2 || n3 == 3) && !hold;
         if (n3 == 3 && hold == 0) hold = 1;
      end
      hold = 0;
      n_checks++;
      if (seen3 != 6) begin
         n_fail++;
         $display("FAIL dwell_hold_len got %0d cycles of out=3 want 6", seen3);
      end
   endtask

   task automatic test_abort();
      logic [CNT_W-1:0] cnt_before;
      int guard;
      set_common(); do_reset(); enable = 1; auto_run = 1;
      guard = 0;
      while (!(m_run && q[0].s == 3) && guard < 12) begin tick(); guard++; end
      abort = 1; tick(); abort = 0;
      n_checks++;
      if (guard >= 12 || {out, busy, done} !== '0 || {out, step, busy, done, run_cnt} !== expv()) begin
         n_fail++;
         $display("FAIL abort_mid got out=%0d busy=%b done=%b guard=%0d want 0,0,0", out, busy, done, guard);
      end
      guard = 0;
      while (!(m_run && q[0].s == 4) && guard < 12) begin tick(); guard++; end
      cnt_before = run_cnt;
      abort = 1; tick();
      n_checks++;
      if (guard >= 12 || done !== 1'b0 || busy !== 1'b0 || run_cnt !== cnt_before) begin
         n_fail++;
         $display("FAIL abort_last got done=%b busy=%b cnt=%0d want 0,0,%0d", done, busy, run_cnt, cnt_before);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || {out, step, busy, done, run_cnt} !== expv()) begin
         n_fail++;
         $display("FAIL abort_idle_blocks_launch got busy=%b want 0", busy);
      end
      abort = 0; auto_run = 0;
   endtask

   task automatic test_manual();
      logic [CNT_W-1:0] want_cnt [5];
      int guard;
      want_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      set_common(); do_reset(); enable = 1;
      for (int i = 0; i < 26; i++) begin
         start = (i == 20) || (i == 23);
         tick();
         n_checks++;
         if ({out, step, busy, done, run_cnt} !== expv()) begin
            n_fail++;
            $display("FAIL manual cyc=%0d got %h want %h", i, {out, step, busy, done, run_cnt}, expv());
         end
      end
      start = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if ({out, step, busy, done, run_cnt} !== expv() || (i > 0 && busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL manual_no_queue cyc=%0d got busy=%b out=%0d want idle", i, busy, out);
         end
      end
      do_reset();
      for (int r = 0; r < 5; r++) begin
         start = 1; tick(); start = 0;
         guard = 0;
         while (!m_done && guard < 10) begin tick(); guard++; end
         n_checks++;
`ifdef FSM_SEQ_RUNCNT_EN
         if (guard >= 10 || done !== 1'b1 || run_cnt !== want_cnt[r]) begin
            n_fail++;
            $display("FAIL run_cnt run=%0d got cnt=%0d done=%b want cnt=%0d done=1", r, run_cnt, done, want_cnt[r]);
         end
`else
         if (guard >= 10 || done !== 1'b1 || run_cnt !== '0) begin
            n_fail++;
            $display("FAIL run_cnt run=%0d got cnt=%0d done=%b want cnt=0 done=1", r, run_cnt, done);
         end
`endif
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (!m_run && $urandom_range(0, 3) == 0) begin
            for (int k = 0; k < NSTEPS; k++) begin
               step_out_tbl[k*OUT_W +: OUT_W]       = OUT_W'($urandom);
               step_dwell_tbl[k*DWELL_W +: DWELL_W] = DWELL_W'($urandom_range(0, 3));
            end
         end
         enable = 1'($urandom);
         start  = ($urandom_range(0, 3) == 0);
         hold   = ($urandom_range(0, 4) == 0);
         abort  = ($urandom_range(0, 24) == 0);
         rstb   = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 29) == 0) auto_run = ~auto_run;
         tick();
         n_checks++;
         if ({out, step, busy, done, run_cnt} !== expv()) begin
            n_fail++;
            $display("FAIL random cyc=%0d got %h want %h", i, {out, step, busy, done, run_cnt}, expv());
         end
      end
      rstb = 1; start = 0; hold = 0; abort = 0; auto_run = 0;
   endtask

   initial begin
      test_reset();
      test_auto_run(1'b1);
      test_auto_run(1'b0);
      test_dwell_hold();
      test_abort();
      test_manual();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
